// File: rtl/three_bit_counter_pkg.sv
// three_bit_counter_pkg
//   Shared definitions for the loadable up-counter: default width, the
//   all-ones terminal count helper, and the next-state selection encoding.
//   Optional feature macro used by the counter files: TBC_WRAP_PULSE_EN.
package three_bit_counter_pkg;

  localparam int TBC_DEFAULT_WIDTH = 3;

  // Which source feeds the next count, in priority order.
  typedef enum logic [1:0] {
    SEL_LOAD = 2'd0,
    SEL_INC  = 2'd1,
    SEL_HOLD = 2'd2
  } tbc_sel_e;

  // Largest value representable in 'width' bits.
  function automatic int unsigned tbc_max(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/three_bit_counter_next.sv
// three_bit_counter_next
//   Purely combinational next-state logic for the counter.
//   Load has priority over increment; increment wraps modulo 2**WIDTH.
//   Optional macro TBC_WRAP_PULSE_EN adds the wrap_next flag.
// Ports
//   ld         in   load strobe
//   inc        in   count enable
//   data_in    in   WIDTH  value to load
//   count      in   WIDTH  current registered count
//   count_next out  WIDTH  count for the next clock
//   wrap_next  out  1 when this step is an increment from all-ones to 0
//                   (TBC_WRAP_PULSE_EN only)
module three_bit_counter_next
  import three_bit_counter_pkg::*;
#(
  parameter int WIDTH = TBC_DEFAULT_WIDTH
) (
  input  logic             ld,
  input  logic             inc,
  input  logic [WIDTH-1:0] data_in,
  input  logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] count_next
`ifdef TBC_WRAP_PULSE_EN
  ,
  output logic             wrap_next
`endif
);

  localparam logic [WIDTH-1:0] COUNT_MAX = WIDTH'(tbc_max(WIDTH));

  tbc_sel_e sel;

  always_comb begin
    sel = SEL_HOLD;
    if (ld) begin
      sel = SEL_LOAD;
    end else if (inc) begin
      sel = SEL_INC;
    end
  end

  always_comb begin
    count_next = count;
    case (sel)
      SEL_LOAD: count_next = data_in;
      // Carry out of the MSB is dropped, giving modulo arithmetic.
      SEL_INC:  count_next = count + WIDTH'(1);
      default:  count_next = count;
    endcase
  end

`ifdef TBC_WRAP_PULSE_EN
  // Only an increment out of all-ones counts as a wrap; loading 0 does not.
  assign wrap_next = (sel == SEL_INC) && (count == COUNT_MAX);
`endif

endmodule

// File: rtl/three_bit_counter.sv
// three_bit_counter
//   Loadable up-counter with synchronous load and count enable. The
//   registered count drives data_out directly; no combinational path from
//   inputs to outputs. Optional macro TBC_WRAP_PULSE_EN adds a registered
//   one-cycle wrap pulse.
// Ports
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-low reset (0 clears all flops)
//   ld        in   synchronous load strobe (wins over inc)
//   inc       in   synchronous count enable
//   data_in   in   WIDTH  value captured when ld==1
//   data_out  out  WIDTH  current count
//   wrap      out  1 for the cycle after count steps all-ones -> 0 by inc
//                  (TBC_WRAP_PULSE_EN only)
module three_bit_counter
  import three_bit_counter_pkg::*;
#(
  parameter int WIDTH = TBC_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic             inc,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
`ifdef TBC_WRAP_PULSE_EN
  ,
  output logic             wrap
`endif
);

  logic [WIDTH-1:0] count_next;
`ifdef TBC_WRAP_PULSE_EN
  logic             wrap_next;
`endif

  three_bit_counter_next #(
    .WIDTH(WIDTH)
  ) u_next (
    .ld        (ld),
    .inc       (inc),
    .data_in   (data_in),
    .count     (data_out),
    .count_next(count_next)
`ifdef TBC_WRAP_PULSE_EN
    ,
    .wrap_next (wrap_next)
`endif
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out <= '0;
    end else begin
      data_out <= count_next;
    end
  end

`ifdef TBC_WRAP_PULSE_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrap <= 1'b0;
    end else begin
      wrap <= wrap_next;
    end
  end
`endif

endmodule

// File: tb/tb_three_bit_counter.sv
// tb_three_bit_counter
//   Directed bench for three_bit_counter. A behavioural model tracks the
//   expected count/wrap and is compared on every falling clock edge;
//   directed steps also check hand-computed literal values.
//   Honors TBC_WRAP_PULSE_EN when defined.
module tb_three_bit_counter;

  localparam int W   = 3;
  localparam int MOD = 1 << W;

  logic         clk;
  logic         rst;
  logic         ld;
  logic         inc;
  logic [W-1:0] data_in;
  logic [W-1:0] data_out;
`ifdef TBC_WRAP_PULSE_EN
  logic         wrap;
`endif

  int n_vec  = 0;
  int n_fail = 0;

  three_bit_counter #(
    .WIDTH(W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ld      (ld),
    .inc     (inc),
    .data_in (data_in),
    .data_out(data_out)
`ifdef TBC_WRAP_PULSE_EN
    ,
    .wrap    (wrap)
`endif
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Behavioural model: plain integer arithmetic on the spec's rules.
  int m_count = 0;
  int m_wrap  = 0;

  always @(posedge clk or negedge rst) begin
    if (rst !== 1'b1) begin
      m_count <= 0;
      m_wrap  <= 0;
    end else if (ld) begin
      m_count <= int'(data_in);
      m_wrap  <= 0;
    end else if (inc) begin
      m_count <= (m_count + 1) % MOD;
      m_wrap  <= (m_count == MOD - 1) ? 1 : 0;
    end else begin
      m_wrap  <= 0;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Continuous compare against the model, away from the active edge.
  always @(negedge clk) begin
    check("model_count", int'(data_out), m_count);
`ifdef TBC_WRAP_PULSE_EN
    check("model_wrap", int'(wrap), m_wrap);
`endif
  end

  task automatic check_wrap(input string name, input int exp);
`ifdef TBC_WRAP_PULSE_EN
    check(name, int'(wrap), exp);
`endif
  endtask

  // Advance to 5 time units past the next rising edge.
  task automatic tick();
    @(posedge clk);
    #5;
  endtask

  int exp_seq [8] = '{1, 2, 3, 4, 5, 6, 7, 0};

  initial begin
    rst     = 1'b1;
    ld      = 1'b0;
    inc     = 1'b1;
    data_in = '0;
    #1 rst  = 1'b0;
    #4;
    check("reset_count", int'(data_out), 0);
    check_wrap("reset_wrap", 0);

    // Held in reset across one rising edge, then released.
    tick();
    check("reset_held", int'(data_out), 0);
    rst = 1'b1;

    // Count 1..7 then wrap to 0.
    for (int i = 0; i < 8; i++) begin
      tick();
      check("count_seq", int'(data_out), exp_seq[i]);
      check_wrap("count_seq_wrap", (i == 7) ? 1 : 0);
    end
    tick();
    check("after_wrap", int'(data_out), 1);
    check_wrap("wrap_one_cycle", 0);

    // Load 5, then count 6, 7, 0.
    ld = 1'b1; data_in = 3'd5;
    tick();
    check("load5", int'(data_out), 5);
    ld = 1'b0; inc = 1'b1;
    tick();
    check("load5_inc6", int'(data_out), 6);
    tick();
    check("load5_inc7", int'(data_out), 7);
    tick();
    check("load5_inc0", int'(data_out), 0);
    check_wrap("load5_wrap", 1);

    // Load and inc together at count 6: load wins.
    ld = 1'b1; inc = 1'b0; data_in = 3'd6;
    tick();
    check("load6", int'(data_out), 6);
    ld = 1'b1; inc = 1'b1; data_in = 3'd3;
    tick();
    check("load_wins", int'(data_out), 3);

    // Loading 0 from 7 is not a wrap.
    ld = 1'b1; inc = 1'b0; data_in = 3'd7;
    tick();
    check("load7", int'(data_out), 7);
    ld = 1'b1; inc = 1'b1; data_in = 3'd0;
    tick();
    check("load0_from7", int'(data_out), 0);
    check_wrap("load0_no_wrap", 0);

    // Hold at 4 for five cycles.
    ld = 1'b1; inc = 1'b0; data_in = 3'd4;
    tick();
    ld = 1'b0; inc = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold4", int'(data_out), 4);
    end

    // Asynchronous reset between edges at count 5.
    ld = 1'b1; data_in = 3'd5;
    tick();
    check("pre_async5", int'(data_out), 5);
    ld = 1'b0; inc = 1'b0;
    #3 rst = 1'b0;
    #1;
    check("async_clear", int'(data_out), 0);
    check_wrap("async_wrap", 0);
    tick();
    check("async_held", int'(data_out), 0);
    rst = 1'b1; inc = 1'b1;
    tick();
    check("resume1", int'(data_out), 1);

    inc = 1'b0;
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
